// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_Control encodings (common with the ALU control
// decoder) and the execute-stage FSM state type.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_SLL = 3'b011,
        ALU_CMP = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_exec_state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result handshake bundle of the ALU execute stage.
// master = issuing core side, slave = alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      ALU_Control;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_Result;
    logic            Zero;
    logic            busy;

    modport master (
        output in_valid, ALU_Control, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALU_Result, Zero, busy
    );

    modport slave (
        input  in_valid, ALU_Control, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALU_Result, Zero, busy
    );
endinterface

// File: rtl/alu_core.sv
// Combinational operation evaluation for the execute stage.
// With ALU_EXEC_BARREL_SHIFT_EN defined, LEFT_SHIFT is a full barrel shift.
// Otherwise LEFT_SHIFT yields only the first step of the iterative shift
// (A for shamt 0, A<<1 otherwise); the parent iterates the remainder.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    // Decode the operation; unlisted codes fall back to ADD.
    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_CMP: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            ALU_SLL: y = a << b[SHAMT_W-1:0];
`else
            ALU_SLL: y = (b[SHAMT_W-1:0] == '0) ? a : {a[XLEN-2:0], 1'b0};
`endif
            default: y = a + b;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Registered RV32 execute stage with valid/ready on issue and result sides.
// Build option ALU_EXEC_BARREL_SHIFT_EN: single-cycle LEFT_SHIFT; when
// undefined, LEFT_SHIFT iterates one bit per cycle through the SHIFT state.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    alu_exec_unit_if.slave bus
);
    alu_exec_state_t state;
    logic [XLEN-1:0] result;
    logic            zero_q;
    logic            out_valid_q;
    logic [XLEN-1:0] core_y;
    logic            accept;

    assign bus.in_ready   = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.ALU_Result = result;
    assign bus.Zero       = zero_q;

    alu_core #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .op (bus.ALU_Control),
        .a  (bus.SrcA),
        .b  (bus.SrcB),
        .y  (core_y)
    );

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    assign bus.busy = 1'b0;

    // Every op completes in one cycle: load result on accept, release on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result      <= '0;
            zero_q      <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
        end else if (accept) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result      <= core_y;
            zero_q      <= (core_y == '0);
        end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
        end
    end
`else
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    acc_shl;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic               busy_q;
    logic               multi_step;

    // The first shift step is taken in the accept cycle (core_y = A<<1), so
    // the counter is loaded with shamt-1 and out_valid rises shamt cycles
    // after accept; shamt 0 and 1 finish like any single-cycle op.
    assign shamt      = bus.SrcB[SHAMT_W-1:0];
    assign multi_step = (bus.ALU_Control == ALU_SLL) && (shamt > SHAMT_W'(1));
    assign acc_shl    = {acc[XLEN-2:0], 1'b0};
    assign bus.busy   = busy_q;

    // FSM: IDLE/DONE accept new ops; SHIFT shifts the accumulator one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result      <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            cnt         <= '0;
        end else if (accept) begin
            if (multi_step) begin
                state       <= SHIFT;
                out_valid_q <= 1'b0;
                zero_q      <= 1'b0;
                busy_q      <= 1'b1;
                acc         <= core_y;
                cnt         <= shamt - SHAMT_W'(1);
            end else begin
                state       <= DONE;
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
                result      <= core_y;
                zero_q      <= (core_y == '0);
            end
        end else begin
            case (state)
                SHIFT: begin
                    acc <= acc_shl;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        result      <= acc_shl;
                        zero_q      <= (acc_shl == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        zero_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`endif
endmodule
